// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared arbiter state encoding and burst limit default
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_e;

    localparam int unsigned MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mux_arbiter_8_mux2.sv
// rtl/mux_arbiter_8_mux2.sv - shared 8-bit 2:1 data mux
module mux_arbiter_8_mux2 (
    input  logic       sel,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic [7:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_arbiter_8.sv
// rtl/mux_arbiter_8.sv - two-requester burst arbiter feeding one registered output beat
module mux_arbiter_8
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       mux_sel,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_src,
    output logic       out_last,
    input  logic       out_ready
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_src_q, out_src_d;
    logic       out_last_q, out_last_d;

    logic [7:0] mux_data;
    logic       slot_free;
    logic       sel_valid;
    logic       sel_last;
    logic       other_valid;
    logic       accept;
    logic       release_burst;
    logic [3:0] cnt_inc;
    logic       enter;
    logic       enter_idx;

    mux_arbiter_8_mux2 u_data_mux (
        .sel (mux_sel),
        .in0 (req0_data),
        .in1 (req1_data),
        .out (mux_data)
    );

    assign mux_sel       = (state_q == ST_GRANT1);
    assign slot_free     = !out_valid_q || out_ready;
    assign req0_ready    = (state_q == ST_GRANT0) && slot_free;
    assign req1_ready    = (state_q == ST_GRANT1) && slot_free;
    assign sel_valid     = mux_sel ? req1_valid : req0_valid;
    assign sel_last      = mux_sel ? req1_last : req0_last;
    assign other_valid   = mux_sel ? req0_valid : req1_valid;
    assign accept        = (state_q != ST_IDLE) && slot_free && sel_valid;
    assign cnt_inc       = beat_cnt_q + 4'd1;
    assign release_burst = accept && (sel_last || (cnt_inc == BURST_LIMIT));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_last_d   = out_last_q;
        enter        = 1'b0;
        enter_idx    = 1'b0;

        if (accept) begin
            beat_cnt_d  = cnt_inc;
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_src_d   = mux_sel;
            out_last_d  = sel_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // On a tie last_grant_q picks the requester that was not served last
                if (req0_valid && (!req1_valid || last_grant_q)) begin
                    enter     = 1'b1;
                    enter_idx = 1'b0;
                end else if (req1_valid) begin
                    enter     = 1'b1;
                    enter_idx = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (release_burst) begin
                    if (other_valid) begin
                        enter     = 1'b1;
                        enter_idx = !mux_sel;
                    end else if (sel_valid) begin
                        enter     = 1'b1;
                        enter_idx = mux_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter) begin
            state_d      = enter_idx ? ST_GRANT1 : ST_GRANT0;
            last_grant_d = enter_idx;
            beat_cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 4'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_src_q    <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_arbiter_8.sv
// tb/tb_mux_arbiter_8.sv - randomized and directed bench for mux_arbiter_8 against a reference model
module tb_mux_arbiter_8;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic       mux_sel, out_valid, out_src, out_last;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;

    always #5 clk = ~clk;

    mux_arbiter_8 #(.MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .mux_sel    (mux_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the grant (-1 = nobody), tie-break memory, burst count, output slot
    int         m_grant = -1;
    int         m_last  = 1;
    int         m_cnt   = 0;
    bit         m_ov    = 0;
    logic [7:0] m_od    = 8'h00;
    bit         m_os    = 0;
    bit         m_ol    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grant = -1; m_last = 1; m_cnt = 0;
            m_ov = 0; m_od = 8'h00; m_os = 0; m_ol = 0;
        end else begin : step
            bit         v[2];
            logic [7:0] d[2];
            bit         l[2];
            bit         sf;
            int         g, o, pick;
            v[0] = req0_valid; v[1] = req1_valid;
            d[0] = req0_data;  d[1] = req1_data;
            l[0] = req0_last;  l[1] = req1_last;
            sf = !m_ov || out_ready;
            if (m_grant < 0) begin
                if (m_ov && out_ready) m_ov = 0;
                pick = -1;
                if (v[0] && v[1]) pick = 1 - m_last;
                else if (v[0]) pick = 0;
                else if (v[1]) pick = 1;
                if (pick >= 0) begin m_grant = pick; m_last = pick; m_cnt = 0; end
            end else begin
                g = m_grant; o = 1 - g;
                if (v[g] && sf) begin
                    m_ov = 1; m_od = d[g]; m_os = g[0]; m_ol = l[g];
                    m_cnt++;
                    if (l[g] || m_cnt == MB) begin
                        if (v[o]) begin m_grant = o; m_last = o; m_cnt = 0; end
                        else if (v[g]) begin m_last = g; m_cnt = 0; end
                        else m_grant = -1;
                    end
                end else if (out_ready) begin
                    m_ov = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("req0_ready", req0_ready, (m_grant == 0) && (!m_ov || out_ready));
        chk("req1_ready", req1_ready, (m_grant == 1) && (!m_ov || out_ready));
        chk("mux_sel", mux_sel, m_grant == 1);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_os);
        chk("out_last", out_last, m_ol);
    end

    // Requester drivers: each queue entry is {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit rnd_mode = 0, hold0 = 0, hold1 = 0;

    always @(posedge clk) begin
        bit f0, f1;
        f0 = req0_valid && req0_ready;
        f1 = req1_valid && req1_ready;
        #1;
        if (f0 && q0.size() > 0) void'(q0.pop_front());
        if (f1 && q1.size() > 0) void'(q1.pop_front());
        req0_valid = (q0.size() > 0) && !hold0 && (!rnd_mode || $urandom_range(3) != 0);
        req1_valid = (q1.size() > 0) && !hold1 && (!rnd_mode || $urandom_range(3) != 0);
        req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
        req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end

    int cyc = 0;
    int srcq[$];
    int cycq[$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            srcq.push_back(int'(out_src));
            cycq.push_back(cyc);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        q0.delete(); q1.delete();
        hold0 = 0; hold1 = 0; out_ready = 1'b1;
        tick(2);
        #2 rst_n = 1'b1;
        srcq.delete(); cycq.delete();
    endtask

    task automatic push_burst(int r, int len, logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            if (r == 0) q0.push_back({(i == len - 1), 8'(base + i)});
            else        q1.push_back({(i == len - 1), 8'(base + i)});
        end
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        out_ready = 1'b1; hold0 = 0; hold1 = 0;
        while ((q0.size() > 0 || q1.size() > 0 || out_valid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drain_in_budget"}, n < budget, 1);
        #2;
    endtask

    task automatic check_seq(string name, string exp);
        chk({name, "_count"}, srcq.size(), exp.len());
        for (int i = 0; i < exp.len() && i < srcq.size(); i++)
            chk({name, "_src"}, srcq[i], int'(exp[i]) - 48);
    endtask

    initial begin
        int n;
        logic [7:0] held;

        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // single beat from requester 0
        @(posedge clk); q0.push_back({1'b1, 8'h11});
        @(posedge clk);
        @(negedge clk);
        chk("single_grant0_ready", req0_ready, 1);
        chk("single_mux_sel", mux_sel, 0);
        @(posedge clk);
        @(negedge clk);
        chk("single_out_valid", out_valid, 1);
        chk("single_out_data", out_data, 8'h11);
        chk("single_out_src", out_src, 0);
        chk("single_out_last", out_last, 1);
        drain("single", 50);

        // both requesters, single-beat bursts alternate with no gaps
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            push_burst(0, 1, 8'(8'h20 + i));
            push_burst(1, 1, 8'(8'h30 + i));
        end
        drain("alt", 100);
        check_seq("alt", "01010101");
        for (int i = 1; i < cycq.size(); i++) chk("alt_gap", cycq[i] - cycq[i-1], 1);

        // 6-beat burst from requester 1 split by MAX_BURST
        do_reset();
        @(posedge clk); push_burst(1, 6, 8'h40);
        @(posedge clk); push_burst(0, 1, 8'h50);
        drain("split", 100);
        check_seq("split", "1111011");

        // output stall holds data and blocks both readies
        do_reset();
        @(posedge clk); push_burst(0, 3, 8'h60);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("stall_saw_valid", out_valid, 1);
        @(posedge clk);
        #2 out_ready = 1'b0;
        held = out_data;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data_stable", out_data, held);
            chk("stall_ready0", req0_ready, 0);
            chk("stall_ready1", req1_ready, 0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain("stall", 50);
        check_seq("stall", "000");

        // asynchronous reset mid-burst
        do_reset();
        @(posedge clk); push_burst(0, 4, 8'h70);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 8'h00);
        chk("arst_out_src", out_src, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_mux_sel", mux_sel, 0);
        chk("arst_ready0", req0_ready, 0);
        q0.delete(); q1.delete();
        tick(2);
        #2 rst_n = 1'b1;
        srcq.delete(); cycq.delete();
        @(posedge clk);
        push_burst(0, 1, 8'h80);
        push_burst(1, 1, 8'h90);
        drain("arst_tie", 50);
        check_seq("arst_tie", "01");

        // requester 0 pauses mid-burst; grant must not move
        do_reset();
        @(posedge clk); push_burst(0, 3, 8'hA0);
        @(posedge clk); push_burst(1, 1, 8'hB0);
        @(posedge clk); hold0 = 1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ready1", req1_ready, 0);
            chk("hold_mux_sel", mux_sel, 0);
        end
        @(posedge clk); hold0 = 0;
        drain("hold", 50);
        check_seq("hold", "0001");

        // randomized traffic against the model
        do_reset();
        rnd_mode = 1;
        repeat (4000) begin
            @(posedge clk);
            if (q0.size() == 0 && $urandom_range(2) == 0)
                push_burst(0, int'($urandom_range(7, 1)), 8'($urandom));
            if (q1.size() == 0 && $urandom_range(2) == 0)
                push_burst(1, int'($urandom_range(7, 1)), 8'($urandom));
            #2 out_ready = ($urandom_range(3) != 0);
        end
        rnd_mode = 0;
        drain("random", 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_8.md
MUX_ARBITER_8 -- requirements
Module: mux_arbiter_8

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum beats per grant before forced re-arbitration (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  SHALL indicate that requester 0 / 1 offers a beat.
REQ-005 req0_data / req1_data  input  8  SHALL carry the requester's beat data.
REQ-006 req0_last / req1_last  input  1  SHALL mark the final beat of a burst.
REQ-007 req0_ready / req1_ready  output  1  SHALL indicate that the beat is accepted this cycle when valid is also high.
REQ-008 mux_sel  output  1  SHALL drive the select of the shared 8-bit 2:1 data mux (0 = requester 0).
REQ-009 out_valid  output  1, out_data  output  8, out_src  output  1, out_last  output  1  SHALL form the registered output beat.
REQ-010 out_ready  input  1  SHALL be downstream backpressure.

Function
REQ-011 FSM states SHALL be IDLE, GRANT0 and GRANT1; mux_sel SHALL be 1 only in GRANT1.
REQ-012 The output stage SHALL be able to accept a beat ("slot_free") when out_valid==0 or out_ready==1.
REQ-013 reqN_ready SHALL be 1 only when the FSM is in GRANTN and slot_free is true; the non-granted ready SHALL be 0.
REQ-014 An accepted beat SHALL appear on out_* exactly 1 cycle later, with out_src equal to the granted index.
REQ-015 out_valid SHALL clear on out_ready when no new beat is accepted; out_* SHALL hold stable while out_valid && !out_ready.
REQ-016 IDLE transitions: only req0_valid -> GRANT0; only req1_valid -> GRANT1; both -> the requester not equal to last_grant; none -> remain in IDLE.
REQ-017 last_grant SHALL update to N on every entry into GRANTN.
REQ-018 beat_cnt (4-bit) SHALL reset to 0 on grant entry and increment per accepted beat.
REQ-019 Release SHALL occur on an accepted beat with last==1, or on an accepted beat that makes beat_cnt equal to MAX_BURST.
REQ-020 On release from GRANTN, the next state SHALL be: GRANT(other) if the other requester's valid==1; else GRANTN (with count reset) if reqN_valid==1; else IDLE. This re-arbitration SHALL complete with no bubble cycle.
REQ-021 A requester deasserting valid mid-burst SHALL NOT cause a release; the grant SHALL hold until REQ-019 is met.
REQ-022 Arbitration in IDLE SHALL take 1 cycle; the first beat SHALL be accepted no earlier than the cycle after the request is first seen in IDLE.
REQ-023 Simultaneous release and output stall: if slot_free==0, no beat SHALL be accepted, beat_cnt SHALL NOT change, and no release SHALL occur.

Reset
REQ-024 On rst_n low: state=IDLE, last_grant=1 (so requester 0 wins the first tie), beat_cnt=0, out_valid=0, out_data=8'h00, out_src=0, out_last=0, mux_sel=0, both readies=0.
REQ-025 Reset asserted mid-burst SHALL discard any in-flight output beat; after rst_n rises, the first arbitration SHALL behave as if from power-up.

Structure
REQ-026 FSM state encoding (2-bit) and the MAX_BURST default SHALL live in the shared package cpu_pkg.
REQ-027 The data path SHALL instantiate the existing 8-bit 2:1 mux as a sub-module, driven by mux_sel; this block SHALL contain no other data mux.

Verification
REQ-028 Reset, then req0_valid=1 with data 0x11, last=1, out_ready=1 -> GRANT0; out_data=0x11, out_src=0 one cycle after acceptance.
REQ-029 Both requesters valid continuously, single-beat bursts -> out_src sequence 0,1,0,1 with no idle cycles after the first grant.
REQ-030 Requester 1 sends a 6-beat burst (last on beat 6) while requester 0 waits, MAX_BURST=4 -> 4 beats from source 1, then 1 beat from source 0, then the remaining 2 beats from source 1.
REQ-031 out_ready held at 0 for 3 cycles with out_valid=1 -> out_data stable, both readies 0, beat_cnt unchanged; normal flow resumes when out_ready returns to 1.
REQ-032 rst_n pulsed low during beat 2 of a burst -> all outputs take their reset values immediately; the next tie is granted to requester 0.
REQ-033 Requester 0 drops valid after beat 1 of a 3-beat burst while requester 1 is valid -> the grant stays on 0 and req1_ready=0 until requester 0's last beat is accepted.
